// File: rtl/instr_mem_pkg.sv
// instr_mem_pkg
//   Shared types and constants for the loadable instruction memory.
//   - state_e       : fetch FSM states (IDLE, WAIT, RESP)
//   - ILLEGAL_INSTR : word returned for misaligned / out-of-range fetches
//   - ERR_CNT_W     : width of the saturating error counter
//   - sat_inc       : saturating increment used by the error counter
package instr_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] ILLEGAL_INSTR = 32'h0000_0000;
  localparam int unsigned ERR_CNT_W     = 8;

  // Increment by one, sticking at all-ones.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    if (v == {ERR_CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// instr_mem_array
//   DEPTH x 32 synchronous RAM, one write port and one read port.
//   The read register only updates on re, so it keeps the word captured at
//   the accept edge regardless of later writes. rkill substitutes KILL_WORD
//   for the array contents (used for faulting fetches).
// Ports:
//   clk, rst_n        clock, async active-low reset (read register only)
//   we, waddr, wdata  write port
//   re, raddr, rkill  read strobe, word index, substitute-kill-word
//   rdata             registered read data
module instr_mem_array #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] KILL_WORD = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  input  logic                     rkill,
  output logic [31:0]              rdata
);

  logic [31:0] mem_r [DEPTH];
  logic [31:0] rdata_r;

  // Write port; storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read register, captured only on a read strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= 32'h0000_0000;
    end else if (re) begin
      rdata_r <= rkill ? KILL_WORD : mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/instr_mem_pipe.sv
// instr_mem_pipe
//   Loadable instruction memory in front of the fetch stage. Fetches use a
//   valid/ready request and response handshake with LATENCY cycles from
//   accept to response. Misaligned or out-of-range fetches return
//   ILLEGAL_INSTR with rsp_err set and bump a saturating error counter when
//   the response is consumed. flush abandons an in-flight fetch.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_valid, req_ready, req_addr fetch request (byte address)
//   rsp_valid, rsp_ready           fetch response handshake
//   rsp_instr, rsp_err             response word and fault flag
//   flush                          drop any in-flight fetch
//   ld_en, ld_addr, ld_data        word load port (any state)
//   err_count                      saturating count of consumed error responses
module instr_mem_pipe
  import instr_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_instr,
  output logic                     rsp_err,
  input  logic                     flush,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data,
  output logic [ERR_CNT_W-1:0]     err_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  // A single-cycle latency never uses the counter; keep it one bit wide.
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e               state_r, state_n;
  logic [CNT_W-1:0]     cnt_r, cnt_n;
  logic                 accept_s;
  logic                 handshake_s;
  logic                 err_s;
  logic                 rsp_valid_r;
  logic                 rsp_err_r;
  logic [ERR_CNT_W-1:0] err_count_r;

  assign req_ready = (state_r == IDLE) && !ld_en && !flush;

  // Fault check on the incoming byte address.
  assign err_s = (req_addr[1:0] != 2'b00) || ((req_addr >> 2) >= ADDR_W'(DEPTH));

  // State and latency counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  // Next-state logic; flush overrides everything outside IDLE.
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    accept_s    = 1'b0;
    handshake_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid && req_ready) begin
          accept_s = 1'b1;
          if (LATENCY > 1) begin
            state_n = WAIT;
            cnt_n   = CNT_W'(LATENCY - 1);
          end else begin
            state_n = RESP;
          end
        end else begin
          state_n = IDLE;
        end
      end
      WAIT: begin
        if (flush) begin
          state_n = IDLE;
          cnt_n   = {CNT_W{1'b0}};
        end else if (cnt_r == CNT_W'(1)) begin
          // Counter is about to reach zero: response is valid next cycle.
          state_n = RESP;
          cnt_n   = {CNT_W{1'b0}};
        end else begin
          cnt_n = cnt_r - CNT_W'(1);
        end
      end
      RESP: begin
        if (flush) begin
          state_n = IDLE;
        end else if (rsp_ready) begin
          handshake_s = 1'b1;
          state_n     = IDLE;
        end else begin
          state_n = RESP;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Response flags and error counter; a flushed response is never counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      err_count_r <= {ERR_CNT_W{1'b0}};
    end else begin
      rsp_valid_r <= (state_n == RESP);
      if (accept_s) begin
        rsp_err_r <= err_s;
      end
      if (handshake_s && rsp_err_r) begin
        err_count_r <= sat_inc(err_count_r);
      end
    end
  end

  instr_mem_array #(
    .DEPTH     (DEPTH),
    .KILL_WORD (ILLEGAL_INSTR)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ld_en),
    .waddr (ld_addr),
    .wdata (ld_data),
    .re    (accept_s),
    .raddr (req_addr[IDX_W+1:2]),
    .rkill (err_s),
    .rdata (rsp_instr)
  );

  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign err_count = err_count_r;

endmodule

// File: doc/instr_mem_pipe.md
# instr_mem_pipe

Parametrised, loadable instruction memory that replaces the fixed combinational program ROM in front of the fetch stage. It holds DEPTH 32-bit words, is filled at run time through a word-wide load port, and serves fetches over a valid/ready request/response handshake with a configurable read latency. It flags misaligned and out-of-range fetches, supports a flush for branch redirects, and keeps a saturating error counter.

## Interface
- ADDR_W, 32, byte-address width of req_addr
- DEPTH, 256, number of 32-bit words (power of two, 16..4096)
- LATENCY, 1, accept-to-response cycles (1..8)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  fetch request valid
- req_ready  out  1  block can accept a request
- req_addr  in  ADDR_W  byte address of fetch
- rsp_valid  out  1  response valid
- rsp_ready  in  1  fetch stage consumes response
- rsp_instr  out  32  instruction word
- rsp_err  out  1  fetch was misaligned or out of range
- flush  in  1  abandon in-flight fetch
- ld_en  in  1  write one word into the array
- ld_addr  in  $clog2(DEPTH)  word index for load
- ld_data  in  32  word to write
- err_count  out  8  saturating count of error responses

## Operation
- FSM states: IDLE, WAIT, RESP.
- req_ready = (state==IDLE) && !ld_en && !flush.
- Accept on any edge with req_valid && req_ready:
  - latch the word index req_addr[ADDR_W-1:2];
  - err = (req_addr[1:0]!=0) || (req_addr>>2 >= DEPTH);
  - read the array at that edge; later loads do not change the captured word.
- On error: rsp_instr = 32'h0000_0000, rsp_err = 1, err_count += 1 (saturates at 255).
- IDLE -> WAIT on accept if LATENCY>1 (counter loaded with LATENCY-1), else -> RESP.
- WAIT: decrement each cycle; -> RESP when the counter reaches 0.
- RESP: rsp_valid=1; rsp_instr and rsp_err are held stable until rsp_ready; -> IDLE on the handshake edge.
- flush (highest priority): WAIT or RESP -> IDLE on that edge. The in-flight response is dropped with no handshake, and err_count is not incremented for the dropped fetch.
- Load: ld_en writes ld_data to mem[ld_addr] on the edge, in any state. It blocks acceptance only in that cycle.
- Array contents are not reset.

## Timing
- Reset values: state=IDLE, rsp_valid=0, rsp_instr=0, rsp_err=0, err_count=0. req_ready is 1 after reset unless ld_en or flush is asserted.
- Latency: accept at edge E. rsp_valid goes high after edge E+LATENCY-1, so with LATENCY=1 it is valid in the next cycle.
- Throughput: one fetch per LATENCY+1 cycles when rsp_ready is held high. No accept occurs in the response-handshake cycle.
- rsp_valid is never withdrawn without rsp_ready, except by flush or reset.
- Reset mid-operation: response is lost, state returns to IDLE, err_count is cleared.
- flush and rsp_ready in the same cycle: flush wins and no handshake is counted.
- Counter width: $clog2(LATENCY).

## Structure
- Package instr_mem_pkg holds:
  - state enum (IDLE, WAIT, RESP);
  - ILLEGAL_INSTR = 32'h0000_0000;
  - ERR_CNT_W = 8.
- Sub-module instr_mem_array: single-port-write, single-port-read synchronous RAM (DEPTH x 32, write-first not required). The FSM, error check and counter live in instr_mem_pipe.

## Test plan
- Load mem[0..3] = 00000093, 02400093, 00102023, 01c00113; fetch 0x04 with LATENCY=1 and rsp_ready=1 -> rsp_valid one cycle after accept, rsp_instr=02400093, rsp_err=0.
- LATENCY=3; fetch 0x08 with rsp_ready=0 for 5 cycles -> rsp_valid rises 3 cycles after accept; 00102023 is held stable until rsp_ready; req_ready=0 throughout.
- Fetch 0x06, then fetch 0x400 with DEPTH=256 -> both give rsp_err=1 and rsp_instr=0; err_count=2.
- Flush one cycle after accept (LATENCY=3) -> no rsp_valid; req_ready=1 next cycle; a new fetch of 0x0C returns 01c00113.
- ld_en and req_valid asserted together in IDLE -> request stalls one cycle, then is accepted. Load mem[1] while a fetch of 0x04 is in WAIT -> the old word is returned.
- Force 300 misaligned fetches -> err_count=255. Assert rst_n=0 mid-WAIT -> all outputs at reset values immediately.
